trivia_answer_judge: RTL and testbench

- Downstream consumer of the 2-bit "correct answer" PIO output.
- Per question: latches the CPU-supplied correct answer on an arm strobe, then takes debounced player key presses and runs a countdown timeout.
- Produces a verdict (correct / wrong / timeout) and maintains a saturating score.
- Verdict, chosen key and score return to the CPU through input PIOs.

---
 rtl/trivia_pkg.sv | 17 +
 rtl/key_debounce.sv | 44 ++++
 rtl/trivia_answer_judge.sv | 113 +++++++++++
 tb/tb_trivia_answer_judge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/trivia_pkg.sv
// Shared encodings for the trivia answer judge: verdict codes, FSM states, key count.
package trivia_pkg;

    localparam int NUM_KEYS = 4;

    typedef logic [1:0] verdict_t;
    localparam verdict_t VERDICT_NONE    = 2'b00;
    localparam verdict_t VERDICT_CORRECT = 2'b01;
    localparam verdict_t VERDICT_WRONG   = 2'b10;
    localparam verdict_t VERDICT_TIMEOUT = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ARMED  = 2'd1;
    localparam state_t RESULT = 2'd2;

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-FF synchroniser, stability counter, and a one-cycle pulse
// when the debounced level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             synced;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Levels are active-low throughout; 1 means released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            synced <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            synced <= sync_1;
            press  <= 1'b0;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= synced;
                cnt    <= '0;
                press  <= ~synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trivia_answer_judge.sv
// Judges one trivia question at a time: latches the answer on arm, takes the first
// debounced key press or a timeout, and keeps a saturating score of correct answers.
module trivia_answer_judge
    import trivia_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 500000000,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         correct_answer,
    input  logic               arm,
    input  logic [3:0]         key_n,
    input  logic               clear_score,
    output logic               busy,
    output logic               verdict_valid,
    output logic [1:0]         verdict,
    output logic [1:0]         chosen,
    output logic [SCORE_W-1:0] score
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic                arm_q;
    logic                arm_rise;
    logic [NUM_KEYS-1:0] press;
    logic                any_press;
    logic [1:0]          sel;
    logic [1:0]          ans_q;
    logic [TMR_W-1:0]    timer;
    logic                score_inc;
    state_t              state_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk    (clk),
            .reset_n(reset_n),
            .key_n  (key_n[g]),
            .press  (press[g])
        );
    end

    assign arm_rise  = arm & ~arm_q;
    assign any_press = |press;
    assign score_inc = (state_q == ARMED) && any_press && (sel == ans_q);

    // Scan high to low so the lowest pressed index wins.
    always_comb begin
        sel = 2'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press[i]) sel = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q         <= 1'b0;
            state_q       <= IDLE;
            ans_q         <= 2'd0;
            timer         <= '0;
            busy          <= 1'b0;
            verdict_valid <= 1'b0;
            verdict       <= VERDICT_NONE;
            chosen        <= 2'd0;
        end else begin
            arm_q <= arm;
            case (state_q)
                IDLE, RESULT: begin
                    if (arm_rise) begin
                        ans_q         <= correct_answer;
                        timer         <= TMR_INIT;
                        verdict       <= VERDICT_NONE;
                        verdict_valid <= 1'b0;
                        chosen        <= 2'd0;
                        busy          <= 1'b1;
                        state_q       <= ARMED;
                    end
                end
                ARMED: begin
                    timer <= timer - 1'b1;
                    if (any_press) begin
                        chosen        <= sel;
                        verdict       <= (sel == ans_q) ? VERDICT_CORRECT : VERDICT_WRONG;
                        busy          <= 1'b0;
                        verdict_valid <= 1'b1;
                        state_q       <= RESULT;
                    end else if (timer == '0) begin
                        chosen        <= 2'd0;
                        verdict       <= VERDICT_TIMEOUT;
                        busy          <= 1'b0;
                        verdict_valid <= 1'b1;
                        state_q       <= RESULT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score <= '0;
        end else if (clear_score) begin
            score <= '0;
        end else if (score_inc && (score != '1)) begin
            score <= score + 1'b1;
        end
    end

endmodule

// File: tb/tb_trivia_answer_judge.sv
// Directed bench for trivia_answer_judge with a verdict scoreboard queue.
module tb_trivia_answer_judge;
    import trivia_pkg::*;

    localparam int SCORE_W = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0]         correct_answer;
    logic               arm;
    logic [3:0]         key_n;
    logic               clear_score;
    logic               busy;
    logic               verdict_valid;
    logic [1:0]         verdict;
    logic [1:0]         chosen;
    logic [SCORE_W-1:0] score;

    logic [5:0]         exp_q[$];
    logic [SCORE_W-1:0] score_m;
    int                 tests_run = 0;
    int                 fail_cnt  = 0;
    logic [1:0]         a;

    always #5 clk = ~clk;

    trivia_answer_judge #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100),
        .SCORE_W        (SCORE_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .correct_answer(correct_answer),
        .arm           (arm),
        .key_n         (key_n),
        .clear_score   (clear_score),
        .busy          (busy),
        .verdict_valid (verdict_valid),
        .verdict       (verdict),
        .chosen        (chosen),
        .score         (score)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm(input logic [1:0] ans);
        correct_answer = ans;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic push_expected(input logic [1:0] v, input logic [1:0] c, input logic clr);
        if (clr) score_m = '0;
        else if (v == VERDICT_CORRECT && score_m != '1) score_m = score_m + 1'b1;
        exp_q.push_back({v, c, score_m});
    endtask

    task automatic collect(input string tag, input int budget);
        int n;
        logic [5:0] e;
        n = 0;
        while (!verdict_valid && n < budget) begin
            tick(1);
            n++;
        end
        if (!verdict_valid) begin
            check({tag, "_wait"}, 8'(verdict_valid), 8'(1));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check(tag, 8'({verdict, chosen, score}), 8'(e));
            check({tag, "_busy"}, 8'(busy), 8'(0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; key_n = 4'hF; arm = 1'b0; correct_answer = 2'd0;
        clear_score = 1'b0; score_m = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("reset_busy",    8'(busy),          8'(0));
        check("reset_valid",   8'(verdict_valid), 8'(0));
        check("reset_verdict", 8'(verdict),       8'(0));
        check("reset_chosen",  8'(chosen),        8'(0));
        check("reset_score",   8'(score),         8'(0));
        check("reset_state",   8'(dut.state_q),   8'(IDLE));

        // Correct answer on key 2.
        pulse_arm(2'd2);
        check("armed_busy",  8'(busy),          8'(1));
        check("armed_valid", 8'(verdict_valid), 8'(0));
        push_expected(VERDICT_CORRECT, 2'd2, 1'b0);
        key_n = 4'b1011;
        collect("correct", 20);
        key_n = 4'hF;
        tick(10);

        // Bouncing key 3 is rejected, then a steady press gives a wrong verdict.
        pulse_arm(2'd1);
        push_expected(VERDICT_WRONG, 2'd3, 1'b0);
        key_n[3] = 1'b0; tick(1);
        key_n[3] = 1'b1; tick(1);
        key_n[3] = 1'b0; tick(1);
        key_n[3] = 1'b1; tick(6);
        check("bounce_rejected", 8'(verdict_valid), 8'(0));
        key_n[3] = 1'b0;
        collect("wrong", 20);
        key_n = 4'hF;
        tick(10);

        // Timeout lands exactly 100 cycles after the arm edge.
        correct_answer = 2'd0;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        push_expected(VERDICT_TIMEOUT, 2'd0, 1'b0);
        tick(99);
        check("timeout_early", 8'(verdict_valid), 8'(0));
        tick(1);
        collect("timeout", 0);

        // Keys 0 and 1 together: key 0 wins.
        pulse_arm(2'd0);
        push_expected(VERDICT_CORRECT, 2'd0, 1'b0);
        key_n = 4'b1100;
        collect("simultaneous", 20);
        key_n = 4'hF;
        tick(10);

        // Five more correct answers saturate the 2-bit score.
        for (int i = 0; i < 5; i++) begin
            a = 2'($urandom_range(0, 3));
            pulse_arm(a);
            push_expected(VERDICT_CORRECT, a, 1'b0);
            key_n = ~(4'b0001 << a);
            collect("saturate", 20);
            key_n = 4'hF;
            tick(10);
        end
        check("score_saturated", 8'(score), 8'(3));

        // Clear held across a correct verdict wins over the increment.
        a = 2'($urandom_range(0, 3));
        pulse_arm(a);
        push_expected(VERDICT_CORRECT, a, 1'b1);
        key_n = ~(4'b0001 << a);
        clear_score = 1'b1;
        collect("clear_priority", 20);
        clear_score = 1'b0;
        tick(1);
        check("score_cleared", 8'(score), 8'(0));
        key_n = 4'hF;
        tick(10);

        // Key held across arm gives no press; re-arm while armed is ignored.
        key_n = 4'b1101;
        tick(10);
        pulse_arm(2'd1);
        tick(20);
        check("held_no_verdict", 8'(verdict_valid), 8'(0));
        check("held_busy",       8'(busy),          8'(1));
        pulse_arm(2'd3);
        tick(2);
        check("rearm_state", 8'(dut.state_q), 8'(ARMED));
        check("rearm_busy",  8'(busy),        8'(1));
        key_n = 4'hF;
        tick(10);
        push_expected(VERDICT_CORRECT, 2'd1, 1'b0);
        key_n = 4'b1101;
        collect("latched_answer", 20);
        key_n = 4'hF;
        tick(10);

        // Reset mid-question with a press in flight.
        pulse_arm(2'd2);
        tick(5);
        key_n = 4'b1011;
        tick(5);
        reset_n = 1'b0;
        #1;
        check("midreset_busy",    8'(busy),          8'(0));
        check("midreset_valid",   8'(verdict_valid), 8'(0));
        check("midreset_verdict", 8'(verdict),       8'(0));
        check("midreset_chosen",  8'(chosen),        8'(0));
        check("midreset_score",   8'(score),         8'(0));
        check("midreset_state",   8'(dut.state_q),   8'(IDLE));
        tick(2);
        reset_n = 1'b1;
        tick(12);
        check("post_reset_valid", 8'(verdict_valid), 8'(0));
        check("post_reset_state", 8'(dut.state_q),   8'(IDLE));
        key_n = 4'hF;
        check("queue_drained", 8'(exp_q.size()), 8'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
